// File: rtl/uart_tx_port_if.sv
// Write-strobe / status bundle between the LC-3 address decoder and the UART transmitter.
// The decoder side is the master. The transmitter responds as the slave and drives the serial line.
interface uart_tx_port_if;
  logic        LD_UARTDR;
  logic        LD_UARTSR;
  logic [15:0] BUS;
  logic [15:0] UARTSR;
  logic        TXD;
  logic        UART_IRQ;
  logic [1:0]  dbg_state;

  modport master (
    output LD_UARTDR, LD_UARTSR, BUS,
    input  UARTSR, TXD, UART_IRQ, dbg_state
  );

  modport slave (
    input  LD_UARTDR, LD_UARTSR, BUS,
    output UARTSR, TXD, UART_IRQ, dbg_state
  );
endinterface

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter for the LC-3 I/O space.
// A UARTDR store starts a frame. UARTSR reports {READY, IE, OVR} and takes the IE / OVR-clear writes.
module uart_tx_port #(
  parameter int unsigned CLK_DIV = 5208
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_port_if.slave io
);

  localparam int unsigned DIV_W = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t           state;
  logic [7:0]       shift;
  logic [2:0]       bitcnt;
  logic [DIV_W-1:0] divcnt;
  logic             ready;
  logic             ie;
  logic             ovr;
  logic             txd;

  logic bit_end;
  logic ovr_set;
  logic ovr_clr;
  logic unused_bus_bits;

  // Handshake: LD_UARTDR / LD_UARTSR are single-cycle write strobes with no backpressure.
  // Software must poll READY before a UARTDR store. A store while READY=0 is dropped and flagged in OVR.
  assign bit_end = (divcnt == DIV_MAX);
  assign ovr_set = io.LD_UARTDR & ~ready;
  assign ovr_clr = io.LD_UARTSR & io.BUS[13];

  assign unused_bus_bits = ^{io.BUS[15], io.BUS[12:8]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      shift  <= 8'h00;
      bitcnt <= 3'd0;
      divcnt <= '0;
      ready  <= 1'b1;
      ie     <= 1'b0;
      ovr    <= 1'b0;
      txd    <= 1'b1;
    end else begin
      if (io.LD_UARTSR) begin
        ie <= io.BUS[14];
      end
      // An overrun in the same cycle as a write-1-to-clear leaves OVR set.
      ovr <= ovr_set | (ovr & ~ovr_clr);

      case (state)
        S_IDLE: begin
          txd <= 1'b1;
          if (io.LD_UARTDR) begin
            shift  <= io.BUS[7:0];
            ready  <= 1'b0;
            divcnt <= '0;
            bitcnt <= 3'd0;
            txd    <= 1'b0;
            state  <= S_START;
          end
        end

        S_START: begin
          if (bit_end) begin
            divcnt <= '0;
            txd    <= shift[0];
            state  <= S_DATA;
          end else begin
            divcnt <= divcnt + DIV_W'(1);
          end
        end

        S_DATA: begin
          if (bit_end) begin
            divcnt <= '0;
            if (bitcnt == 3'd7) begin
              txd   <= 1'b1;
              state <= S_STOP;
            end else begin
              shift  <= shift >> 1;
              bitcnt <= bitcnt + 3'd1;
              txd    <= shift[1];
            end
          end else begin
            divcnt <= divcnt + DIV_W'(1);
          end
        end

        S_STOP: begin
          if (bit_end) begin
            divcnt <= '0;
            ready  <= 1'b1;
            state  <= S_IDLE;
          end else begin
            divcnt <= divcnt + DIV_W'(1);
          end
        end

        default: begin
          state <= S_IDLE;
          ready <= 1'b1;
          txd   <= 1'b1;
        end
      endcase
    end
  end

  assign io.UARTSR    = {ready, ie, ovr, 13'b0};
  assign io.UART_IRQ  = ready & ie;
  assign io.TXD       = txd;
  assign io.dbg_state = state;

endmodule

// File: tb/tb_uart_tx_port.sv
// Randomized scoreboard bench for uart_tx_port with CLK_DIV=4.
// A time-based frame model predicts TXD and UARTSR every cycle, and a serial monitor decodes frames against queued bytes.
module tb_uart_tx_port;

  localparam int D = 4;

  logic clk;
  logic reset;

  uart_tx_port_if bus_if ();

  uart_tx_port #(.CLK_DIV(D)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus_if)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A frame accepted at edge s occupies edges s .. s+10*D-1.
  // Bit k of the frame covers edges s+k*D .. s+(k+1)*D-1.
  int         cyc = 0;
  bit         m_busy = 0;
  int         m_start = 0;
  logic [7:0] m_byte = 8'h00;
  bit         m_ie = 0;
  bit         m_ovr = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk) begin
    bit rdy;
    bit set_ovr;
    cyc++;
    if (reset) begin
      m_busy = 0;
      m_ie   = 0;
      m_ovr  = 0;
      exp_q.delete();
    end else begin
      rdy     = !m_busy;
      set_ovr = 0;
      if (m_busy && cyc == m_start + 10 * D) m_busy = 0;
      if (bus_if.LD_UARTDR) begin
        if (rdy) begin
          m_busy  = 1;
          m_start = cyc;
          m_byte  = bus_if.BUS[7:0];
          exp_q.push_back(bus_if.BUS[7:0]);
        end else begin
          set_ovr = 1;
        end
      end
      if (bus_if.LD_UARTSR) begin
        m_ie = bus_if.BUS[14];
        if (bus_if.BUS[13]) m_ovr = 0;
      end
      if (set_ovr) m_ovr = 1;
    end
  end

  function automatic logic exp_txd();
    int k;
    if (!m_busy) return 1'b1;
    k = (cyc - m_start) / D;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
    return 1'b1;
  endfunction

  // Per-cycle check of the line and the status word against the model.
  always begin
    @(posedge clk);
    #1;
    if (check_en) begin
      chk("txd_cycle", {15'b0, bus_if.TXD}, {15'b0, exp_txd()});
      chk("uartsr_cycle", bus_if.UARTSR, {!m_busy, m_ie, m_ovr, 13'b0});
      chk("irq_cycle", {15'b0, bus_if.UART_IRQ}, {15'b0, (!m_busy && m_ie)});
    end
  end

  // ---------------- serial monitor / scoreboard ----------------
  initial begin
    logic [9:0] bits;
    int         off;
    bit         aborted;
    logic [7:0] exp_b;
    forever begin
      @(posedge clk);
      #1;
      if (check_en && !reset && bus_if.TXD === 1'b0) begin
        off     = 0;
        aborted = 0;
        bits    = '0;
        for (int k = 0; k < 10; k++) begin
          while (off < k * D + D / 2) begin
            @(posedge clk);
            #1;
            off++;
            if (reset) aborted = 1;
          end
          if (aborted) break;
          bits[k] = bus_if.TXD;
        end
        if (!aborted) begin
          chk("frame_start_bit", {15'b0, bits[0]}, 16'h0000);
          chk("frame_stop_bit", {15'b0, bits[9]}, 16'h0001);
          if (exp_q.size() == 0) begin
            chk("frame_unexpected", {8'h00, bits[8:1]}, 16'hFFFF);
          end else begin
            exp_b = exp_q.pop_front();
            chk("frame_byte", {8'h00, bits[8:1]}, {8'h00, exp_b});
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Strobes are driven on the falling edge and held for exactly one rising edge.
  task automatic pulse_now(input bit dr, input bit sr, input logic [15:0] bus);
    bus_if.LD_UARTDR = dr;
    bus_if.LD_UARTSR = sr;
    bus_if.BUS       = bus;
    @(negedge clk);
    bus_if.LD_UARTDR = 1'b0;
    bus_if.LD_UARTSR = 1'b0;
    bus_if.BUS       = 16'($urandom);
  endtask

  task automatic send(input bit dr, input bit sr, input logic [15:0] bus);
    @(negedge clk);
    pulse_now(dr, sr, bus);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!m_busy && bus_if.UARTSR[15]) done = 1;
    end
    if (!done) chk("wait_idle_timeout", 16'h0000, 16'h0001);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    bit ok;

    reset            = 1'b1;
    bus_if.LD_UARTDR = 1'b0;
    bus_if.LD_UARTSR = 1'b0;
    bus_if.BUS       = 16'h0000;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_txd", {15'b0, bus_if.TXD}, 16'h0001);
    chk("reset_uartsr", bus_if.UARTSR, 16'h8000);
    chk("reset_irq", {15'b0, bus_if.UART_IRQ}, 16'h0000);
    @(negedge clk);
    reset    = 1'b0;
    check_en = 1;

    // Single frame 'A': READY low from edge 0, back high at edge 10*D.
    send(1, 0, 16'h0041);
    chk("a_ready_edge0", {15'b0, bus_if.UARTSR[15]}, 16'h0000);
    chk("a_txd_edge0", {15'b0, bus_if.TXD}, 16'h0000);
    repeat (10 * D - 1) @(negedge clk);
    chk("a_ready_before_end", {15'b0, bus_if.UARTSR[15]}, 16'h0000);
    @(negedge clk);
    chk("a_ready_at_end", {15'b0, bus_if.UARTSR[15]}, 16'h0001);

    // Overrun while busy: the second byte is dropped and OVR sticks.
    send(1, 0, 16'h003C);
    repeat (5) @(negedge clk);
    send(1, 0, 16'h00FF);
    chk("ovr_busy_sr", bus_if.UARTSR, 16'h2000);
    wait_idle();
    chk("ovr_idle_sr", bus_if.UARTSR, 16'hA000);

    // Status writes: set IE with OVR clear, then clear IE with OVR untouched.
    send(0, 1, 16'h6000);
    chk("sr_write_ie", bus_if.UARTSR, 16'hC000);
    chk("sr_write_irq", {15'b0, bus_if.UART_IRQ}, 16'h0001);
    send(0, 1, 16'h0000);
    chk("sr_write_clr", bus_if.UARTSR, 16'h8000);
    chk("sr_write_irq0", {15'b0, bus_if.UART_IRQ}, 16'h0000);

    // Back-to-back: the second byte is loaded in the first cycle READY is high.
    send(1, 0, 16'h0055);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus_if.UARTSR[15]) ok = 1;
    end
    chk("b2b_ready_seen", {15'b0, ok}, 16'h0001);
    pulse_now(1, 0, 16'h00AA);
    chk("b2b_second_started", {15'b0, bus_if.UARTSR[15]}, 16'h0000);
    chk("b2b_no_ovr", {15'b0, bus_if.UARTSR[13]}, 16'h0000);
    wait_idle();

    // Busy IRQ: with IE=1 the IRQ drops for exactly one frame.
    send(0, 1, 16'h4000);
    chk("irq_ie_set", {15'b0, bus_if.UART_IRQ}, 16'h0001);
    send(1, 0, {8'h00, 8'($urandom)});
    n = 0;
    while (bus_if.UART_IRQ == 1'b0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("irq_low_cycles", 16'(n), 16'(10 * D));

    // Reset in the middle of a data bit that is currently 0.
    send(1, 0, 16'h00C3);
    repeat (13) @(negedge clk);
    chk("pre_reset_txd", {15'b0, bus_if.TXD}, 16'h0000);
    reset = 1'b1;
    #1;
    chk("midreset_txd", {15'b0, bus_if.TXD}, 16'h0001);
    chk("midreset_uartsr", bus_if.UARTSR, 16'h8000);
    chk("midreset_irq", {15'b0, bus_if.UART_IRQ}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus_if.TXD === 1'b1) n++;
    end
    chk("post_reset_idle_50", 16'(n), 16'd50);

    // Random mix of loads, status writes, collisions and idle gaps.
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: send(1, 0, 16'($urandom));
        4, 5:       send(0, 1, 16'($urandom));
        6:          send(1, 1, 16'($urandom));
        default:    repeat ($urandom_range(1, 45)) @(negedge clk);
      endcase
    end
    wait_idle();
    repeat (2 * D) @(negedge clk);
    chk("scoreboard_empty", 16'(exp_q.size()), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
